// File: rtl/can_crc_engine_pkg.sv
// Shared constants and state type for the CAN CRC engine: standard CAN/CAN FD
// generator polynomials, FD init values and the engine FSM encoding.
package can_pkg;
  localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;
  localparam logic [16:0] CAN_CRC17_POLY = 17'h1685B;
  localparam logic [20:0] CAN_CRC21_POLY = 21'h102899;

  localparam logic [16:0] CAN_CRC17_INIT = 17'h10000;
  localparam logic [20:0] CAN_CRC21_INIT = 21'h100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SHIFT = 2'd2,
    ST_RXCRC = 2'd3
  } crc_state_t;
endpackage

// File: rtl/crc_lfsr_step.sv
// One MSB-first LFSR step of a CRC register; shared by accumulate and rx-check paths.
module crc_lfsr_step
  import can_pkg::*;
#(
  parameter int               CRC_W = 15,
  parameter logic [CRC_W-1:0] POLY  = CAN_CRC15_POLY
) (
  input  logic [CRC_W-1:0] crc,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_next
);
  logic fb;

  always_comb begin
    fb       = bit_in ^ crc[CRC_W-1];
    crc_next = {crc[CRC_W-2:0], 1'b0};
    if (fb) crc_next = crc_next ^ POLY;
  end
endmodule

// File: rtl/can_crc_engine.sv
// Configurable CAN CRC engine: accumulates the frame, then serialises the CRC
// field (tx) or absorbs the received CRC field and reports the residue (rx).
module can_crc_engine
  import can_pkg::*;
#(
  parameter int               CRC_W         = 15,
  parameter logic [CRC_W-1:0] POLY          = CAN_CRC15_POLY,
  parameter logic [CRC_W-1:0] INIT          = '0,
  parameter bit               INCLUDE_STUFF = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             stuff_bit,
  input  logic             end_field,
  input  logic             shift_en,
  output logic [CRC_W-1:0] crc_out,
  output logic             crc_bit,
  output logic             crc_bit_valid,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [1:0]       dbg_state
);
  localparam int               CNT_W = $clog2(CRC_W + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CRC_W - 1);

  crc_state_t       state, state_next;
  logic [CRC_W-1:0] crc, crc_next, shreg;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic             eff;
  logic             last;

  // bit_valid has no ready: the engine takes every valid bit in ACCUM/RXCRC;
  // stuff bits are dropped unless INCLUDE_STUFF folds them in.
  assign eff  = bit_valid & (~stuff_bit | INCLUDE_STUFF);
  assign last = (cnt == LAST);

  crc_lfsr_step #(.CRC_W(CRC_W), .POLY(POLY)) u_step (
    .crc      (crc),
    .bit_in   (bit_in),
    .crc_next (crc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = ST_IDLE;
    end else if (start) begin
      state_next = ST_ACCUM;
    end else begin
      case (state)
        ST_ACCUM: if (end_field)       state_next = mode_q ? ST_RXCRC : ST_SHIFT;
        ST_SHIFT: if (shift_en && last) state_next = ST_IDLE;
        ST_RXCRC: if (eff && last)      state_next = ST_IDLE;
        default:                        state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy          = (state != ST_IDLE);
    crc_bit_valid = (state == ST_SHIFT);
    crc_bit       = (state == ST_SHIFT) ? shreg[CRC_W-1] : 1'b0;
    dbg_state     = state;
    crc_out       = crc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc     <= INIT;
      shreg   <= '0;
      cnt     <= '0;
      mode_q  <= 1'b0;
      done    <= 1'b0;
      crc_ok  <= 1'b0;
      crc_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        cnt     <= '0;
        crc_ok  <= 1'b0;
        crc_err <= 1'b0;
      end else if (start) begin
        crc     <= INIT;
        cnt     <= '0;
        mode_q  <= mode;
        crc_ok  <= 1'b0;
        crc_err <= 1'b0;
      end else begin
        case (state)
          ST_ACCUM: begin
            if (eff) crc <= crc_next;
            // The marker bit itself belongs to the CRC, so load what crc becomes.
            if (end_field) shreg <= eff ? crc_next : crc;
          end
          ST_SHIFT: begin
            if (shift_en) begin
              shreg <= {shreg[CRC_W-2:0], 1'b0};
              cnt   <= last ? '0 : cnt + CNT_W'(1);
              done  <= last;
            end
          end
          ST_RXCRC: begin
            if (eff) begin
              crc <= crc_next;
              cnt <= last ? '0 : cnt + CNT_W'(1);
              if (last) begin
                done    <= 1'b1;
                crc_ok  <= (crc_next == '0);
                crc_err <= (crc_next != '0);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_can_crc_engine.sv
// Bench for can_crc_engine: three instances (CRC-15, CRC-15 with stuff bits,
// CRC-17 FD) share stimulus and are checked every cycle against a
// polynomial-division model.
module tb_can_crc_engine;
  import can_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start, abort, mode, bit_in, bit_valid, stuff_bit, end_field, shift_en;

  logic [14:0] crc_a, crc_s;
  logic [16:0] crc_f;
  logic        cb_a, cb_s, cb_f, cbv_a, cbv_s, cbv_f, busy_a, busy_s, busy_f;
  logic        done_a, done_s, done_f, ok_a, ok_s, ok_f, err_a, err_s, err_f;
  logic [1:0]  st_a, st_s, st_f;

  can_crc_engine dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .bit_in(bit_in), .bit_valid(bit_valid), .stuff_bit(stuff_bit),
    .end_field(end_field), .shift_en(shift_en), .crc_out(crc_a),
    .crc_bit(cb_a), .crc_bit_valid(cbv_a), .busy(busy_a), .done(done_a),
    .crc_ok(ok_a), .crc_err(err_a), .dbg_state(st_a));

  can_crc_engine #(.INCLUDE_STUFF(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .bit_in(bit_in), .bit_valid(bit_valid), .stuff_bit(stuff_bit),
    .end_field(end_field), .shift_en(shift_en), .crc_out(crc_s),
    .crc_bit(cb_s), .crc_bit_valid(cbv_s), .busy(busy_s), .done(done_s),
    .crc_ok(ok_s), .crc_err(err_s), .dbg_state(st_s));

  can_crc_engine #(.CRC_W(17), .POLY(17'h1685B), .INIT(17'h10000), .INCLUDE_STUFF(1'b0)) dut_f (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .bit_in(bit_in), .bit_valid(bit_valid), .stuff_bit(stuff_bit),
    .end_field(end_field), .shift_en(shift_en), .crc_out(crc_f),
    .crc_bit(cb_f), .crc_bit_valid(cbv_f), .busy(busy_f), .done(done_f),
    .crc_ok(ok_f), .crc_err(err_f), .dbg_state(st_f));

  logic [31:0] o_crc[3];
  logic        o_bit[3], o_cbv[3], o_busy[3], o_done[3], o_ok[3], o_err[3];
  logic [1:0]  o_dbg[3];
  assign o_crc[0] = {17'd0, crc_a};
  assign o_crc[1] = {17'd0, crc_s};
  assign o_crc[2] = {15'd0, crc_f};
  assign o_bit[0] = cb_a;    assign o_bit[1] = cb_s;    assign o_bit[2] = cb_f;
  assign o_cbv[0] = cbv_a;   assign o_cbv[1] = cbv_s;   assign o_cbv[2] = cbv_f;
  assign o_busy[0] = busy_a; assign o_busy[1] = busy_s; assign o_busy[2] = busy_f;
  assign o_done[0] = done_a; assign o_done[1] = done_s; assign o_done[2] = done_f;
  assign o_ok[0] = ok_a;     assign o_ok[1] = ok_s;     assign o_ok[2] = ok_f;
  assign o_err[0] = err_a;   assign o_err[1] = err_s;   assign o_err[2] = err_f;
  assign o_dbg[0] = st_a;    assign o_dbg[1] = st_s;    assign o_dbg[2] = st_f;

  // Per-instance configuration and behavioural model state (index 3 = scratch queue).
  int          p_w[3]    = '{15, 15, 17};
  logic [31:0] p_poly[3] = '{32'h4599, 32'h4599, 32'h1685B};
  logic [31:0] p_init[3] = '{32'h0, 32'h0, 32'h10000};
  bit          p_inc[3]  = '{1'b0, 1'b1, 1'b0};

  int m_phase[3];  // 0 idle, 1 accumulate, 2 tx shift, 3 rx crc field
  int m_k[3];
  bit m_mode[3], m_done[3], m_ok[3], m_err[3];
  bit m_q[4][$];

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Remainder of (init * x^n + M(x) * x^w) mod G(x) by long division.
  function automatic logic [31:0] model_crc(input int w, input logic [31:0] poly,
                                            input logic [31:0] init, input int qi);
    bit dv[$];
    int n;
    logic [31:0] r;
    n = m_q[qi].size();
    for (int i = 0; i < n + w; i++)
      dv.push_back(((i < w) ? init[w-1-i] : 1'b0) ^ ((i < n) ? m_q[qi][i] : 1'b0));
    for (int i = 0; i < n; i++) begin
      if (dv[i]) begin
        dv[i] = 1'b0;
        for (int j = 1; j <= w; j++) dv[i+j] = dv[i+j] ^ poly[w-j];
      end
    end
    r = '0;
    for (int k = 0; k < w; k++) r[w-1-k] = dv[n+k];
    return r;
  endfunction

  function automatic logic [31:0] exp_crc(input int d);
    return model_crc(p_w[d], p_poly[d], p_init[d], d);
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m_phase[d] = 0; m_k[d] = 0; m_mode[d] = 1'b0;
      m_done[d] = 1'b0; m_ok[d] = 1'b0; m_err[d] = 1'b0;
      m_q[d].delete();
    end
  endfunction

  function automatic void model_step();
    bit eff;
    for (int d = 0; d < 3; d++) begin
      m_done[d] = 1'b0;
      eff = bit_valid && (!stuff_bit || p_inc[d]);
      if (abort) begin
        m_phase[d] = 0; m_ok[d] = 1'b0; m_err[d] = 1'b0;
      end else if (start) begin
        m_phase[d] = 1; m_mode[d] = mode; m_k[d] = 0;
        m_ok[d] = 1'b0; m_err[d] = 1'b0;
        m_q[d].delete();
      end else begin
        case (m_phase[d])
          1: begin
            if (eff) m_q[d].push_back(bit_in);
            if (end_field) begin
              m_phase[d] = m_mode[d] ? 3 : 2;
              m_k[d] = 0;
            end
          end
          2: if (shift_en) begin
            m_k[d]++;
            if (m_k[d] == p_w[d]) begin m_phase[d] = 0; m_done[d] = 1'b1; end
          end
          3: if (eff) begin
            m_q[d].push_back(bit_in);
            m_k[d]++;
            if (m_k[d] == p_w[d]) begin
              m_phase[d] = 0; m_done[d] = 1'b1;
              m_ok[d] = (exp_crc(d) == 0);
              m_err[d] = !m_ok[d];
            end
          end
          default: ;
        endcase
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
  endtask

  task automatic cyc(input logic s, input logic a, input logic m, input logic b,
                     input logic v, input logic st, input logic ef, input logic sh);
    start = s; abort = a; mode = m; bit_in = b;
    bit_valid = v; stuff_bit = st; end_field = ef; shift_en = sh;
    tick();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        logic [31:0] r;
        r = exp_crc(d);
        check($sformatf("busy%0d", d), o_busy[d], m_phase[d] != 0);
        check($sformatf("dbg%0d", d), o_dbg[d] == 2'(ST_IDLE), m_phase[d] == 0);
        check($sformatf("cbv%0d", d), o_cbv[d], m_phase[d] == 2);
        check($sformatf("done%0d", d), o_done[d], m_done[d]);
        check($sformatf("ok%0d", d), o_ok[d], m_ok[d]);
        check($sformatf("err%0d", d), o_err[d], m_err[d]);
        check($sformatf("crc%0d", d), o_crc[d], r);
        check($sformatf("cbit%0d", d), o_bit[d], (m_phase[d] == 2) ? r[p_w[d]-1-m_k[d]] : 1'b0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] got, v15;
    logic [31:0] r;
    int n, pos;
    logic ab;
    start = 0; abort = 0; mode = 0; bit_in = 0;
    bit_valid = 0; stuff_bit = 0; end_field = 0; shift_en = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    check("rst_crc_a", crc_a, 15'h0000);
    check("rst_crc_f", crc_f, 17'h10000);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done_ok_err", {done_a, ok_a, err_a}, 3'b000);
    check("rst_cbit", {cb_a, cbv_a}, 2'b00);

    m_q[3].delete(); m_q[3].push_back(1'b1);
    check("model_pin_1", model_crc(15, 32'h4599, 32'h0, 3), 32'h4599);
    m_q[3].push_back(1'b0);
    check("model_pin_10", model_crc(15, 32'h4599, 32'h0, 3), 32'h4EAB);

    // tx of a single '1': CRC field equals the polynomial.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 1, 0);
    check("tx1_crc", crc_a, 15'h4599);
    got = '0;
    for (int i = 0; i < 15; i++) begin
      got[14-i] = cb_a;
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
    end
    check("tx1_bits", got, 15'b100010110011001);
    check("tx1_done", done_a, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("tx1_done_pulse", done_a, 1'b0);

    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 1, 0);
    check("tx10_crc", crc_a, 15'h4EAB);

    // Restart in the middle of SHIFT.
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("restart_crc", crc_a, 15'h0000);
    check("restart_busy", {busy_a, cbv_a, done_a}, 3'b100);
    check("restart_crc_f", crc_f, 17'h10000);

    // rx with the correct CRC field, then with one bit flipped.
    v15 = 15'h4599;
    for (int pass = 0; pass < 2; pass++) begin
      cyc(1, 0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, 1, 0);
      pos = $urandom_range(0, 14);
      for (int i = 0; i < 15; i++)
        cyc(0, 0, 0, v15[14-i] ^ ((pass == 1) && (i == pos)), 1, 0, 0, 0);
      check("rx_done", done_a, 1'b1);
      check("rx_ok_err", {ok_a, err_a}, (pass == 0) ? 2'b10 : 2'b01);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      check("rx_hold", {done_a, ok_a, err_a}, (pass == 0) ? 3'b010 : 3'b001);
    end

    // A stuff bit is dropped by the CAN 2.0 instance and folded in by the FD-style one.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 1, 0, 0);
    check("stuff_excl", crc_a, 15'h4EAB);
    check("stuff_incl", crc_s, 15'h1D56);
    cyc(0, 0, 0, 0, 1, 0, 1, 0);

    // abort during RXCRC.
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    check("abort_state", {busy_a, done_a, ok_a, err_a}, 4'b0000);

    // Reset mid-ACCUM acts immediately.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0, 0);
    start = 0; bit_valid = 0; bit_in = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_busy", {busy_a, busy_f, cbv_a, cb_a}, 4'b0000);
    check("rst_mid_crc_a", crc_a, 15'h0000);
    check("rst_mid_crc_f", crc_f, 17'h10000);
    check("rst_mid_flags", {done_a, ok_a, err_a}, 3'b000);
    tick();
    tick();
    rst_n = 1'b1;

    // CAN FD CRC-17 rx round trip of a random 40-bit frame with stuff bits sprinkled in.
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) cyc(0, 0, 0, $urandom_range(0, 1), 1, 1, 0, 0);
      cyc(0, 0, 0, $urandom_range(0, 1), 1, 0, i == 39, 0);
    end
    r = exp_crc(2);
    for (int i = 0; i < 17; i++) cyc(0, 0, 0, r[16-i], 1, 0, 0, 0);
    check("fd_done", done_f, 1'b1);
    check("fd_ok", {ok_f, err_f}, 2'b10);

    // Random frames; a done is followed immediately by the next start.
    for (int f = 0; f < 40; f++) begin
      cyc(1, 0, $urandom_range(0, 1), 0, 0, 0, 0, 0);
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++)
        cyc(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, i == n - 1, $urandom_range(0, 1));
      for (int j = 0; j < 40; j++) begin
        ab = ($urandom_range(0, 49) == 0);
        cyc($urandom_range(0, 79) == 0, ab, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        if (done_a || ab) break;
      end
    end

    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/can_crc_engine.md
# can_crc_engine

Parametrised CRC engine for the CAN 2.0B/FD bit stream, with a tx path that shifts out the CRC field and an rx path that checks it. It supersedes the fixed CRC-15 accumulator with a configurable width, polynomial, init value and stuff-bit policy. It sits between the bit-stream processor (destuffed or stuffed bit feed) and the frame FSMs. It accumulates from SOF through end of data, then either shifts the CRC field out serially (tx) or absorbs the received CRC field and reports the residue check (rx).

## Interface
Parameters:
- CRC_W, 15: CRC width; legal values 15, 17, 21.
- POLY, 15'h4599: generator polynomial without the x^CRC_W term; bit i is the x^i coefficient.
- INIT, 0: register value loaded on start. CAN FD uses 1 << (CRC_W-1).
- INCLUDE_STUFF, 0: 1 means bits flagged as stuff bits are folded into the CRC (FD style).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  load INIT and enter ACCUM.
- abort  in  1  return to IDLE; no done pulse.
- mode  in  1  sampled on start. 0 = tx, 1 = rx.
- bit_in  in  1  serial bit.
- bit_valid  in  1  bit_in is valid this cycle.
- stuff_bit  in  1  qualifies bit_in as a stuff bit.
- end_field  in  1  last data bit marker, used in ACCUM.
- shift_en  in  1  tx: advance the CRC field by one bit.
- crc_out  out  CRC_W  live CRC register.
- crc_bit  out  1  tx serial CRC bit, MSB first.
- crc_bit_valid  out  1  high while in SHIFT.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at the end of SHIFT or RXCRC.
- crc_ok  out  1  rx residue was zero; held until next start.
- crc_err  out  1  rx residue was nonzero; held until next start.

## Operation
- States: IDLE, ACCUM, SHIFT (tx), RXCRC (rx).
- LFSR step, MSB-first: fb = bit_in ^ crc[CRC_W-1]; crc_next = (crc << 1) truncated to CRC_W bits, XOR POLY when fb = 1.
- A bit is "effective" when bit_valid is high and (stuff_bit is low or INCLUDE_STUFF = 1). Non-effective bits leave crc and the counter unchanged.
- IDLE:
  - Ignores bit_valid.
  - start -> ACCUM, crc = INIT, mode latched, counter cleared, crc_ok and crc_err cleared.
- ACCUM:
  - Each effective bit applies one LFSR step.
  - end_field with bit_valid: that bit is included first.
  - end_field -> SHIFT if tx, RXCRC if rx.
  - end_field arriving with a non-effective bit (stuff bit, INCLUDE_STUFF = 0) still transitions.
- SHIFT:
  - Shift register is loaded with crc at entry.
  - crc_bit = shift-register MSB.
  - Each shift_en shifts left and increments the counter.
  - After the CRC_W-th shift_en -> IDLE with done = 1. crc_out keeps the final CRC.
- RXCRC:
  - Effective bits continue LFSR steps and increment the counter.
  - On the CRC_W-th effective bit -> IDLE with done = 1.
  - crc_ok = (crc_next == 0); crc_err = its inverse.
- Priority: abort > start > everything else.
  - start in any non-IDLE state restarts cleanly; no done is generated.
  - abort clears busy and leaves crc_ok and crc_err at 0.
- Counter width: $clog2(CRC_W+1). It never wraps, because the exit happens at CRC_W.

## Timing
- Reset values:
  - state = IDLE, crc = INIT, shift register = 0, counter = 0.
  - crc_bit = 0, crc_bit_valid = 0, busy = 0, done = 0, crc_ok = 0, crc_err = 0.
- Reset mid-operation behaves the same as reset from any other state.
- crc_out reflects an effective bit one cycle after the bit is accepted.
- The state transition on end_field takes effect on the next edge. crc_bit is valid on the first SHIFT cycle.
- done, crc_ok and crc_err are registered and update on the same edge; done is high for exactly one cycle.
- shift_en outside SHIFT and bit_valid in SHIFT are ignored.
- Back-to-back operation: start in the cycle after done is accepted with no bubble.

## Structure
- Package can_pkg holds:
  - polynomial constants: CAN_CRC15_POLY = 15'h4599, CAN_CRC17_POLY = 17'h1685B, CAN_CRC21_POLY = 21'h102899;
  - FD init constants;
  - the crc_state_t enum.
- One sub-module, crc_lfsr_step (purely combinational, parametrised CRC_W and POLY), computes crc_next. It is reused by the tx and rx paths.

## Test plan
- Defaults, mode = 0: start, one bit '1' with end_field -> crc_out = 15'h4599. The next 15 shift_en pulses give crc_bit sequence 100010110011001, then done.
- Defaults, bits '1','0', then end_field -> crc_out = 15'h4EAB.
- Rx, mode = 1: message '1', then CRC bits of 15'h4599 MSB first -> done with crc_ok = 1. Flip one CRC bit -> crc_err = 1.
- Stuff handling: a '1' with stuff_bit = 1 inserted mid-stream leaves crc unchanged when INCLUDE_STUFF = 0. With INCLUDE_STUFF = 1 it changes crc.
- Control events:
  - start asserted mid-SHIFT -> ACCUM with crc = INIT and no done.
  - abort in RXCRC -> IDLE, crc_ok = crc_err = 0.
  - rst_n low mid-ACCUM -> all outputs at reset values immediately.
- CRC_W = 17, POLY = 17'h1685B, INIT = 17'h10000: rx round trip of a random 40-bit frame against a reference model -> crc_ok = 1.
